// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : boot loader, host byte stream -> instruction-memory words
// Revision    : 1.0
// ============================================================================
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam logic [2:0] S_HDR_HI = 3'd0;
    localparam logic [2:0] S_HDR_LO = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CSUM   = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [7:0]  n_hi;
    logic [15:0] n_words;
    logic [1:0]  byte_idx;
    logic [23:0] word_sr;
    logic [7:0]  csum;

    logic        accept;
    logic [15:0] hdr_n;
    logic [15:0] cnt_ext;
    logic        last_byte;
    logic        final_word;

    assign accept     = in_valid && in_ready;
    assign hdr_n      = {n_hi, in_data};
    assign cnt_ext    = 16'(word_cnt);
    assign last_byte  = (byte_idx == 2'd3);
    // word_cnt still holds the pre-increment count while the last byte is taken
    assign final_word = ((cnt_ext + 16'd1) == n_words);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_HDR_HI;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (load_req) begin
            state_nx = S_HDR_HI;
        end else if (accept) begin
            case (state)
                S_HDR_HI: state_nx = S_HDR_LO;
                S_HDR_LO: begin
                    if (hdr_n > 16'(MAX_WORDS)) begin
                        state_nx = S_ERR;
                    end else if (hdr_n == 16'd0) begin
                        state_nx = S_CSUM;
                    end else begin
                        state_nx = S_DATA;
                    end
                end
                S_DATA: begin
                    if (last_byte && final_word) begin
                        state_nx = S_CSUM;
                    end
                end
                S_CSUM:  state_nx = (csum == in_data) ? S_RUN : S_ERR;
                default: state_nx = state;
            endcase
        end
    end

    always_comb begin
        in_ready = 1'b0;
        cpu_rst  = 1'b1;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            S_HDR_HI: in_ready = !load_req;
            S_HDR_LO, S_DATA, S_CSUM: begin
                in_ready = !load_req;
                busy     = 1'b1;
            end
            S_RUN: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            S_ERR:   err = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_hi     <= 8'd0;
            n_words  <= 16'd0;
            byte_idx <= 2'd0;
            word_sr  <= 24'd0;
            csum     <= 8'd0;
            word_cnt <= '0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= 32'd0;
        end else begin
            im_we <= 1'b0;
            if (load_req) begin
                byte_idx <= 2'd0;
                word_sr  <= 24'd0;
                csum     <= 8'd0;
                word_cnt <= '0;
                n_words  <= 16'd0;
            end else if (accept) begin
                case (state)
                    S_HDR_HI: n_hi <= in_data;
                    S_HDR_LO: n_words <= hdr_n;
                    S_DATA: begin
                        csum     <= csum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        word_sr  <= {word_sr[15:0], in_data};
                        if (last_byte) begin
                            im_we    <= 1'b1;
                            im_addr  <= word_cnt[ADDR_W-1:0];
                            im_wdata <= {word_sr, in_data};
                            if (cnt_ext < n_words) begin
                                word_cnt <= word_cnt + (ADDR_W+1)'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
